arp_rx: RTL
===========

Name: arp_rx

Overview:
- Receive-side ARP parser. Consumes the ARP payload byte stream delivered by the MAC receive layer, after the Ethernet header is stripped and EtherType 0x0806 is selected.
- Validates the header and checks the target IP against the local IP.
- For a request addressed to us: raises a reply trigger carrying the requester MAC/IP for the ARP transmitter.
- For a reply addressed to us: publishes the learned peer IP/MAC pair to the ARP table.

Parameters:
- P_SRC_IP, {8'd192,8'd168,8'd10,8'd1}, local IP after reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_src_ip  in  32  new local IP
- i_src_ip_valid  in  1  load i_src_ip into local IP register (single-cycle strobe)
- i_mac_data  in  8  ARP payload byte, first byte = hardware type MSB
- i_mac_valid  in  1  byte qualifier; may deassert mid-frame (gap)
- i_mac_last  in  1  final byte of frame, qualified by i_mac_valid
- o_trig_reply  out  1  1-cycle pulse: valid request for our IP received
- o_reply_mac  out  48  requester (sender) MAC, stable from pulse until next pulse
- o_reply_ip  out  32  requester (sender) IP, same timing as o_reply_mac
- o_peer_valid  out  1  1-cycle pulse: valid reply for our IP received
- o_peer_mac  out  48  sender MAC of reply
- o_peer_ip  out  32  sender IP of reply

Behaviour:
- Reset: all outputs 0; byte counter 0; state IDLE; local IP = P_SRC_IP.
- Local IP register loads i_src_ip when i_src_ip_valid=1. Comparison uses the register value at evaluation time.
- Byte counter r_cnt (16-bit):
  - Increments on each accepted byte (i_mac_valid=1).
  - Saturates at 16'hFFFF.
  - Clears to 0 on an accepted byte with i_mac_last=1.
  - Holds during gaps (i_mac_valid=0).
- Field offsets (r_cnt value when byte accepted):
  - 0-1 htype, must be 0x0001
  - 2-3 ptype, must be 0x0800
  - 4 hlen, must be 6
  - 5 plen, must be 4
  - 6-7 opcode
  - 8-13 sender MAC
  - 14-17 sender IP
  - 18-23 target MAC, ignored
  - 24-27 target IP
  - 28+ padding, ignored
- Multi-byte fields are captured MSB first into internal shift/holding registers. Outputs are not touched until evaluation.
- State machine:
  - IDLE: first accepted byte -> RECV, with that byte processed as offset 0.
  - RECV:
    - Header byte mismatch at offsets 0-5 -> DROP, unless that byte carries last -> IDLE.
    - Accepted byte with last -> evaluate, then IDLE.
  - DROP: discard bytes until an accepted byte with last -> IDLE. No outputs are generated.
- Evaluation, on the last byte in RECV:
  - Frame accepted only if (r_cnt at last byte) >= 27, i.e. at least 28 bytes, and captured target IP == local IP.
  - Opcode 0x0001: next cycle o_trig_reply=1 for exactly one cycle; o_reply_mac/o_reply_ip updated in that same cycle.
  - Opcode 0x0002: next cycle o_peer_valid=1 for exactly one cycle; o_peer_mac/o_peer_ip updated in that same cycle.
  - Any other opcode, short frame, or IP mismatch: no pulse; outputs hold their previous values.
- Latency: pulse appears exactly 1 clock after the accepted last byte.
- Back-to-back frames: a new frame may start on the cycle after last. Evaluation of the previous frame still completes correctly, because captured fields are copied to the outputs on that cycle.
- A single-byte frame (valid+last at offset 0) is discarded.
- Reset mid-frame: abort, return to IDLE, no pulse.

Test Plan:
1. Request, target IP 192.168.10.1, sender MAC 02:11:22:33:44:55, IP 192.168.10.7, 46 bytes incl. padding -> o_trig_reply pulses 1 cycle after last; o_reply_mac=48'h021122334455, o_reply_ip=32'hC0A80A07; o_peer_valid stays 0.
2. Same request with target IP 192.168.10.9 -> no pulses; outputs unchanged.
3. Reply opcode 2, sender 192.168.10.0 / MAC AA:BB:CC:DD:EE:FF, target 192.168.10.1 -> o_peer_valid pulse; o_peer_mac=48'hAABBCCDDEEFF, o_peer_ip=32'hC0A80A00; o_trig_reply stays 0.
4. Malformed frames:
   - htype 0x0006 -> DROP, no pulse.
   - Valid request truncated to 20 bytes -> no pulse.
   - Opcode 3 -> no pulse.
   - Follow each with a good request -> it is answered normally.
5. Request with random i_mac_valid gaps, immediately followed back-to-back by a reply -> both pulses, each 1 cycle after its own last, with correct fields.
6. i_src_ip_valid loads 10.0.0.5. Request to 192.168.10.1 -> ignored. Request to 10.0.0.5 -> answered. Assert i_rst mid-frame -> no pulse; the next frame is parsed correctly.

Source files
------------

// File: rtl/arp_rx.sv
// ARP receive parser: walks the ARP payload byte by byte, checks the fixed
// header, captures sender/target fields and, on the final byte, either
// raises a reply trigger (request for our IP) or publishes a learned peer
// (reply for our IP).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | between frames; next accepted byte is offset 0
// S_RECV | frame in progress, header so far matches
// S_DROP | header mismatch seen; discard until the last byte
module arp_rx #(
   parameter logic [31:0] P_SRC_IP = {8'd192, 8'd168, 8'd10, 8'd1}
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_src_ip,
   input  logic        i_src_ip_valid,
   input  logic [7:0]  i_mac_data,
   input  logic        i_mac_valid,
   input  logic        i_mac_last,
   output logic        o_trig_reply,
   output logic [47:0] o_reply_mac,
   output logic [31:0] o_reply_ip,
   output logic        o_peer_valid,
   output logic [47:0] o_peer_mac,
   output logic [31:0] o_peer_ip
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_local_ip;
   logic [15:0] r_op;
   logic [47:0] r_smac;
   logic [31:0] r_sip;
   logic [31:0] r_tip;

   logic        r_trig;
   logic [47:0] r_reply_mac;
   logic [31:0] r_reply_ip;
   logic        r_peer;
   logic [47:0] r_peer_mac;
   logic [31:0] r_peer_ip;

   logic        w_hdr_bad;
   logic [31:0] w_tip;
   logic        w_accept;

   // Fixed header bytes at offsets 0-5 must read 00 01 08 00 06 04.
   always_comb begin
      w_hdr_bad = 1'b0;
      case (r_cnt)
         16'd0:   w_hdr_bad = (i_mac_data != 8'h00);
         16'd1:   w_hdr_bad = (i_mac_data != 8'h01);
         16'd2:   w_hdr_bad = (i_mac_data != 8'h08);
         16'd3:   w_hdr_bad = (i_mac_data != 8'h00);
         16'd4:   w_hdr_bad = (i_mac_data != 8'h06);
         16'd5:   w_hdr_bad = (i_mac_data != 8'h04);
         default: w_hdr_bad = 1'b0;
      endcase
   end

   // When the last byte is offset 27 the target IP is still one byte short
   // in r_tip, so fold the incoming byte in for the comparison.
   assign w_tip    = (r_cnt == 16'd27) ? {r_tip[23:0], i_mac_data} : r_tip;
   assign w_accept = (r_cnt >= 16'd27) && (w_tip == r_local_ip);

   // Local IP register, reloadable at run time.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_local_ip <= P_SRC_IP;
      else if (i_src_ip_valid)
         r_local_ip <= i_src_ip;
   end

   // Byte offset counter and MSB-first field capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_op   <= '0;
         r_smac <= '0;
         r_sip  <= '0;
         r_tip  <= '0;
      end else if (i_mac_valid) begin
         if (i_mac_last)
            r_cnt <= '0;
         else if (r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;

         if (r_cnt == 16'd6 || r_cnt == 16'd7)
            r_op <= {r_op[7:0], i_mac_data};
         if (r_cnt >= 16'd8 && r_cnt <= 16'd13)
            r_smac <= {r_smac[39:0], i_mac_data};
         if (r_cnt >= 16'd14 && r_cnt <= 16'd17)
            r_sip <= {r_sip[23:0], i_mac_data};
         if (r_cnt >= 16'd24 && r_cnt <= 16'd27)
            r_tip <= {r_tip[23:0], i_mac_data};
      end
   end

   // Frame FSM with registered result outputs; pulses last one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_trig      <= 1'b0;
         r_reply_mac <= '0;
         r_reply_ip  <= '0;
         r_peer      <= 1'b0;
         r_peer_mac  <= '0;
         r_peer_ip   <= '0;
      end else begin
         r_trig <= 1'b0;
         r_peer <= 1'b0;
         case (r_state)
            S_IDLE, S_RECV: begin
               if (i_mac_valid) begin
                  if (i_mac_last) begin
                     // A header mismatch is only possible below offset 6,
                     // where w_accept is already false.
                     r_state <= S_IDLE;
                     if (w_accept && r_op == 16'h0001) begin
                        r_trig      <= 1'b1;
                        r_reply_mac <= r_smac;
                        r_reply_ip  <= r_sip;
                     end else if (w_accept && r_op == 16'h0002) begin
                        r_peer     <= 1'b1;
                        r_peer_mac <= r_smac;
                        r_peer_ip  <= r_sip;
                     end
                  end else if (w_hdr_bad) begin
                     r_state <= S_DROP;
                  end else begin
                     r_state <= S_RECV;
                  end
               end
            end
            S_DROP: begin
               if (i_mac_valid && i_mac_last)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_trig_reply = r_trig;
   assign o_reply_mac  = r_reply_mac;
   assign o_reply_ip   = r_reply_ip;
   assign o_peer_valid = r_peer;
   assign o_peer_mac   = r_peer_mac;
   assign o_peer_ip    = r_peer_ip;

endmodule
